// File: rtl/multiword_adder_sequencer.sv
// Multi-word add/subtract on one shared WIDTH-bit lookahead adder, one word per cycle (LSW first).
// Result valid WORDS cycles after accept; result is held in DONE until result_ready, and no new command is taken meanwhile.

module carry_lookahead_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   logic [WIDTH-1:0] g0, p0, gk, pk;
   logic [WIDTH:0]   c;

   // Kogge-Stone prefix over (generate, propagate); carry_in folds in afterwards
   always_comb begin
      g0 = a & b;
      p0 = a ^ b;
      gk = g0;
      pk = p0;
      for (int s = 1; s < WIDTH; s = s * 2) begin
         for (int i = WIDTH - 1; i >= s; i--) begin
            gk[i] = gk[i] | (pk[i] & gk[i-s]);
            pk[i] = pk[i] & pk[i-s];
         end
      end
      c[0] = carry_in;
      for (int i = 0; i < WIDTH; i++) begin
         c[i+1] = gk[i] | (pk[i] & carry_in);
      end
      sum       = p0 ^ c[WIDTH-1:0];
      carry_out = c[WIDTH];
   end
endmodule

module multiword_adder_sequencer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic                   subtract,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [WIDTH*WORDS-1:0] sum,
   output logic                   carry_out,
   output logic                   overflow,
   output logic                   busy
);
   localparam int N  = WIDTH * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic           carry_q, carry_d;
   logic           sub_q, sub_d;
   logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic           cout_q, cout_d, ovf_q, ovf_d;

   logic [WIDTH-1:0] a_word, b_word, b_eff, add_sum;
   logic             add_cin, add_cout, last_word;

   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (KW'(w) == k_q) begin
            a_word = a_q[w*WIDTH +: WIDTH];
            b_word = b_q[w*WIDTH +: WIDTH];
         end
      end
      b_eff     = sub_q ? ~b_word : b_word;
      add_cin   = (k_q == '0) ? sub_q : carry_q;
      last_word = (k_q == KW'(WORDS - 1));
   end

   carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
      .a         (a_word),
      .b         (b_eff),
      .carry_in  (add_cin),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = subtract;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int w = 0; w < WORDS; w++) begin
               if (KW'(w) == k_q) sum_d[w*WIDTH +: WIDTH] = add_sum;
            end
            carry_d = add_cout;
            if (last_word) begin
               cout_d  = add_cout;
               ovf_d   = (a_word[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != a_word[WIDTH-1]);
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign start_ready  = (state_q == IDLE);
   assign result_valid = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign sum          = sum_q;
   assign carry_out    = cout_q;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed and randomized checks of multiword_adder_sequencer against an arithmetic reference model.
module tb_multiword_adder_sequencer;
   localparam int WIDTH = 8;
   localparam int WORDS = 4;
   localparam int N     = WIDTH * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid, start_ready, subtract;
   logic [N-1:0] a_in, b_in, sum;
   logic         result_valid, result_ready, carry_out, overflow, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multiword_adder_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .subtract     (subtract),
      .a            (a_in),
      .b            (b_in),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .sum          (sum),
      .carry_out    (carry_out),
      .overflow     (overflow),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-operand two's-complement arithmetic
   task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic msub,
                        output logic [N-1:0] esum, output logic ecout, output logic eovf);
      logic [N:0] full;
      if (msub) begin
         esum  = ma - mb;
         ecout = (ma >= mb);
         eovf  = (ma[N-1] != mb[N-1]) && (esum[N-1] != ma[N-1]);
      end else begin
         full  = {1'b0, ma} + {1'b0, mb};
         esum  = full[N-1:0];
         ecout = full[N];
         eovf  = (ma[N-1] == mb[N-1]) && (esum[N-1] != ma[N-1]);
      end
   endtask

   // Called at a negedge while idle; returns at a negedge back in IDLE.
   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tsub,
                        input int hold, input string tag);
      logic [N-1:0] esum;
      logic         ecout, eovf;
      model(ta, tb_v, tsub, esum, ecout, eovf);
      start_valid = 1'b1;
      a_in        = ta;
      b_in        = tb_v;
      subtract    = tsub;
      check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      a_in        = N'($urandom);
      b_in        = N'($urandom);
      subtract    = ~tsub;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      for (int i = 1; i <= WORDS; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_result_valid_timing"}, 64'(result_valid), (i == WORDS) ? 64'd1 : 64'd0);
      end
      check({tag, "_sum"}, 64'(sum), 64'(esum));
      check({tag, "_carry_out"}, 64'(carry_out), 64'(ecout));
      check({tag, "_overflow"}, 64'(overflow), 64'(eovf));
      for (int h = 0; h < hold; h++) begin
         start_valid = (h == 0);
         a_in        = N'($urandom);
         b_in        = N'($urandom);
         @(posedge clk);
         @(negedge clk);
         start_valid = 1'b0;
         check({tag, "_hold_valid"}, 64'(result_valid), 64'd1);
         check({tag, "_hold_start_ready"}, 64'(start_ready), 64'd0);
         check({tag, "_hold_sum"}, 64'({sum, carry_out, overflow}), 64'({esum, ecout, eovf}));
      end
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      check({tag, "_idle_start_ready"}, 64'(start_ready), 64'd1);
      check({tag, "_idle_valid"}, 64'({result_valid, busy}), 64'd0);
      check({tag, "_idle_sum_kept"}, 64'(sum), 64'(esum));
   endtask

   initial begin
      rst_n        = 1'b0;
      start_valid  = 1'b0;
      result_ready = 1'b0;
      subtract     = 1'b0;
      a_in         = '0;
      b_in         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_start_ready", 64'(start_ready), 64'd1);
      check("reset_valid_busy", 64'({result_valid, busy}), 64'd0);
      check("reset_outputs", 64'({sum, carry_out, overflow}), 64'd0);

      do_op(32'h000000FF, 32'h00000001, 1'b0, 0, "add_carry");
      do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "add_cout");
      do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "add_ovf");
      do_op(32'h00000000, 32'h00000001, 1'b1, 0, "sub_borrow");
      do_op(32'h80000000, 32'h00000001, 1'b1, 0, "sub_ovf");
      do_op(32'h12345678, 32'h0F0F0F0F, 1'b0, 3, "backpressure");
      do_op(32'h00000005, 32'h00000003, 1'b1, 0, "after_bp");
      check("after_bp_exact_sum", 64'(sum), 64'h2);

      // Abort after two words, with a command offered during the reset edge
      start_valid = 1'b1;
      a_in        = 32'hDEADBEEF;
      b_in        = 32'h11111111;
      subtract    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n       = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      start_valid = 1'b0;
      check("abort_start_ready", 64'(start_ready), 64'd1);
      check("abort_busy_valid", 64'({busy, result_valid}), 64'd0);
      check("abort_outputs", 64'({sum, carry_out, overflow}), 64'd0);
      do_op(32'h01020304, 32'h10203040, 1'b0, 0, "post_abort");
      check("post_abort_exact_sum", 64'(sum), 64'h11223344);

      for (int r = 0; r < 24; r++) begin
         do_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
